// File: rtl/osc_fll_ctrl.sv
// osc_fll_ctrl: frequency-lock loop that steps a 2-bit ring-oscillator code until the edge count per window hits target
// Ports: clk, rst (async, active-high), en, win_len, target, osc_in (async divided phase)
//        -> ctrl (oscillator code), locked, meas_cnt, meas_valid [, sat_err]
// Optional: define OSC_FLL_SAT_FLAG_EN to add sat_err, flagging a step blocked by code saturation.
module osc_fll_ctrl #(
  parameter int WIN_W      = 12,
  parameter int CNT_W      = 10,
  parameter int DEADBAND   = 1,
  parameter int SETTLE_CYC = 16,
  parameter int LOCK_N     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] target,
  input  logic             osc_in,
  output logic [1:0]       ctrl,
  output logic             locked,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             meas_valid
`ifdef OSC_FLL_SAT_FLAG_EN
  ,
  output logic             sat_err
`endif
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int LW = $clog2(LOCK_N + 1);
  localparam logic signed [CNT_W:0] DB = (CNT_W + 1)'(DEADBAND);
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, UPDATE} state_t;
  state_t state, state_nx;
  logic [2:0] sync;
  logic [SW-1:0] settle_cnt;
  logic [WIN_W-1:0] win_cnt, win_lim;
  logic [CNT_W-1:0] edge_cnt;
  logic [LW-1:0] lock_cnt;
  logic signed [CNT_W:0] diff;
  logic rise, fast, slow, blocked, step;
  logic [1:0] ctrl_nx;
  // sync[1:0] is the two-flop synchronizer, sync[2] the edge-detect history
  assign rise    = sync[1] & ~sync[2];
  assign diff    = $signed({1'b0, edge_cnt}) - $signed({1'b0, target});
  assign fast    = diff > DB;
  assign slow    = diff < -DB;
  assign blocked = (fast && ctrl == 2'd3) || (slow && ctrl == 2'd0);
  assign step    = (fast || slow) && !blocked;
  assign ctrl_nx = fast ? ctrl + 2'd1 : ctrl - 2'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx = state;
    if (!en) state_nx = IDLE;
    else
      case (state)
        IDLE:    state_nx = SETTLE;
        SETTLE:  state_nx = (settle_cnt == SW'(SETTLE_CYC - 1)) ? MEASURE : SETTLE;
        MEASURE: state_nx = (win_cnt == win_lim - WIN_W'(1)) ? UPDATE : MEASURE;
        default: state_nx = step ? SETTLE : MEASURE;
      endcase
  end
  always_comb locked = lock_cnt == LW'(LOCK_N);
  // Counters idle at zero outside their own state, so every entry starts clean.
  // edge_cnt is still valid during UPDATE because its clear lands after meas_cnt samples it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync       <= '0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      win_lim    <= '0;
      edge_cnt   <= '0;
      lock_cnt   <= '0;
      ctrl       <= 2'b01;
      meas_cnt   <= '0;
      meas_valid <= 1'b0;
    end else begin
      sync       <= {sync[1:0], osc_in};
      settle_cnt <= (en && state == SETTLE) ? settle_cnt + SW'(1) : '0;
      win_cnt    <= (en && state == MEASURE) ? win_cnt + WIN_W'(1) : '0;
      edge_cnt   <= (en && state == MEASURE) ? edge_cnt + CNT_W'(rise && !(&edge_cnt)) : '0;
      if (state_nx == MEASURE && state != MEASURE) win_lim <= (win_len == '0) ? WIN_W'(1) : win_len;
      meas_valid <= en && state == UPDATE;
      if (!en) lock_cnt <= '0;
      else if (state == UPDATE) begin
        meas_cnt <= edge_cnt;
        ctrl     <= step ? ctrl_nx : ctrl;
        lock_cnt <= (fast || slow) ? '0 : (locked ? lock_cnt : lock_cnt + LW'(1));
      end
    end
  end
`ifdef OSC_FLL_SAT_FLAG_EN
  always_ff @(posedge clk or posedge rst)
    if (rst)                  sat_err <= 1'b0;
    else if (!en)             sat_err <= 1'b0;
    else if (state == UPDATE) sat_err <= blocked;
`endif
endmodule

// File: tb/tb_osc_fll_ctrl.sv
// tb_osc_fll_ctrl: randomized self-checking bench for osc_fll_ctrl against a timeline reference model
module tb_osc_fll_ctrl;
  localparam int SETTLE = 16, LOCKN = 3, DB = 1, CMAX = 1023;
  logic clk = 0, rst = 1, en = 0, osc_in = 0;
  logic [11:0] win_len = 100;
  logic [9:0] target = 50;
  logic [1:0] ctrl;
  logic locked, meas_valid;
  logic [9:0] meas_cnt;
`ifdef OSC_FLL_SAT_FLAG_EN
  logic sat_err;
`endif
  int vectors = 0, miscompares = 0;
  int per = 4;
  int exp_ctrl = 1, exp_meas = 0, lock_run = 0;
  bit exp_locked = 0, exp_valid = 0, exp_sat = 0, m_ok = 0, m_rise = 0;
  bit [2:0] hist = 0;

  always #5 clk = ~clk;

  osc_fll_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .win_len(win_len), .target(target), .osc_in(osc_in),
    .ctrl(ctrl), .locked(locked), .meas_cnt(meas_cnt), .meas_valid(meas_valid)
`ifdef OSC_FLL_SAT_FLAG_EN
    , .sat_err(sat_err)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the loop as a timeline of phases (settle, window, update),
  // advanced one reference clock at a time; en low or rst aborts back to idle.
  task automatic tick();
    @(posedge clk or posedge rst);
    exp_valid = 0;
    if (rst) begin
      exp_ctrl = 1; exp_meas = 0; exp_locked = 0; exp_sat = 0; lock_run = 0; hist = 0; m_ok = 0;
      return;
    end
    // an osc_in rise seen at clocks k-3 -> k-2 is countable on clock k
    m_rise = hist[1] & ~hist[2];
    hist = {hist[1:0], osc_in};
    m_ok = en;
    if (!en) begin lock_run = 0; exp_locked = 0; exp_sat = 0; end
  endtask

  task automatic run();
    bit go_settle, fast, slow, blocked;
    int wl, n, d;
    go_settle = 1;
    forever begin
      if (go_settle) repeat (SETTLE) begin tick(); if (!m_ok) return; end
      wl = (win_len == 0) ? 1 : int'(win_len);
      n = 0;
      repeat (wl) begin
        tick();
        if (!m_ok) return;
        if (m_rise && n < CMAX) n++;
      end
      tick();
      if (!m_ok) return;
      d = n - int'(target);
      fast = d > DB;
      slow = d < -DB;
      blocked = (fast && exp_ctrl == 3) || (slow && exp_ctrl == 0);
      exp_meas = n; exp_valid = 1; exp_sat = blocked;
      if (fast && !blocked) exp_ctrl++;
      if (slow && !blocked) exp_ctrl--;
      lock_run = (fast || slow) ? 0 : (lock_run < LOCKN ? lock_run + 1 : LOCKN);
      exp_locked = lock_run == LOCKN;
      go_settle = (fast || slow) && !blocked;
    end
  endtask

  initial forever begin
    tick();
    if (m_ok) run();
  end

  initial forever begin
    @(posedge clk);
    #1;
    check("ctrl", ctrl, exp_ctrl);
    check("locked", locked, exp_locked);
    check("meas_cnt", meas_cnt, exp_meas);
    check("meas_valid", meas_valid, exp_valid);
`ifdef OSC_FLL_SAT_FLAG_EN
    check("sat_err", sat_err, exp_sat);
`endif
  end

  // oscillator phase: period per clocks (per=0 gives random 2..6 clock high/low times)
  initial begin
    int left;
    left = 2;
    forever begin
      @(negedge clk);
      left = left - 1;
      if (left <= 0) begin
        osc_in = ~osc_in;
        left = (per > 0) ? (osc_in ? per / 2 : per - per / 2) : int'($urandom_range(2, 6));
      end
    end
  end

  function automatic int cur(input int which);
    return which == 0 ? int'(meas_valid) : which == 1 ? int'(locked) : int'(ctrl);
  endfunction

  task automatic wait_until(input int which, input int val, input int bound, input string tag, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (cur(which) != val && n < bound);
    if (cur(which) != val) check({tag, "_timeout"}, cur(which), val);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_ctrl", ctrl, 1);
    check("rst_locked", locked, 0);
    check("rst_meas", meas_cnt, 0);
    check("rst_valid", meas_valid, 0);
    rst = 0; en = 1;
    wait_until(0, 1, 300, "t1_valid", n);
    check("t1_meas", meas_cnt, 25);
    check("t1_ctrl", ctrl, 0);
    @(negedge clk); rst = 1; target = 10;
    @(negedge clk); rst = 0;
    repeat (4) wait_until(0, 1, 300, "t2_valid", n);
    check("t2_ctrl_sat", ctrl, 3);
    check("t2_locked", locked, 0);
    @(negedge clk); rst = 1; target = 25;
    @(negedge clk); rst = 0;
    wait_until(1, 1, 500, "t3_lock", n);
    check("t3_lock_latency", n, 320);
    check("t3_ctrl", ctrl, 1);
    check("t3_meas", meas_cnt, 25);
    @(negedge clk); per = 5;
    wait_until(1, 0, 300, "t4_unlock", n);
    check("t4_ctrl", ctrl, 0);
    @(negedge clk); per = 4;
    wait_until(1, 1, 1000, "t5_lock", n);
    wait_until(0, 1, 300, "t5_valid", n);
    repeat (50) @(posedge clk);
    @(negedge clk); en = 0;
    @(posedge clk); #1;
    check("t5_en_locked", locked, 0);
    check("t5_en_ctrl", ctrl, 0);
    @(negedge clk); en = 1;
    wait_until(0, 1, 300, "t5_revalid", n);
    check("t5_resettle_latency", n, 118);
    @(negedge clk); target = 10;
    wait_until(2, 3, 1500, "t6_ctrl3", n);
    @(negedge clk); target = 25;
    wait_until(1, 1, 1500, "t6_lock", n);
    check("t6_lock_ctrl", ctrl, 3);
    wait_until(0, 1, 300, "t6_valid", n);
    repeat (40) @(posedge clk);
    @(negedge clk); rst = 1;
    #1;
    check("t6_arst_ctrl", ctrl, 1);
    check("t6_arst_locked", locked, 0);
    check("t6_arst_meas", meas_cnt, 0);
    win_len = 0;
    @(negedge clk); rst = 0;
    repeat (5) begin
      wait_until(0, 1, 100, "t6_w1_valid", n);
      check("t6_w1_meas_le1", int'(meas_cnt <= 1), 1);
    end
    for (int e = 0; e < 25; e++) begin
      @(negedge clk);
      per = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(4, 12));
      win_len = ($urandom_range(0, 4) == 0) ? 12'($urandom_range(0, 3)) : 12'($urandom_range(20, 200));
      target = 10'($urandom_range(0, 60));
      if ($urandom_range(0, 5) == 0) begin
        rst = 1;
        @(negedge clk);
        rst = 0;
      end
      for (int c = 0; c < 800; c++) begin
        @(negedge clk);
        en = ($urandom_range(0, 299) != 0);
        if ($urandom_range(0, 199) == 0) target = 10'($urandom_range(0, 60));
        if ($urandom_range(0, 399) == 0) win_len = 12'($urandom_range(0, 150));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/osc_fll_ctrl.md
Name: osc_fll_ctrl

Overview:
- Digital frequency-lock controller directly upstream of the 5-phase ring oscillator model; drives its 2-bit `ctrl` input.
- Counts rising edges of a divided oscillator phase over a fixed window of `clk` cycles and compares the count with a programmed target.
- Steps `ctrl` up or down one code per window until the count is within a deadband, then reports lock.
- Oscillator mapping: period = 800 ps + 100 ps·ctrl[1] + 50 ps·ctrl[0]. Higher code means a longer period and lower frequency.

Parameters:
- WIN_W, 12, width of window-length input and window counter.
- CNT_W, 10, width of edge counter, target and measurement.
- DEADBAND, 1, max |meas − target| accepted as on-frequency.
- SETTLE_CYC, 16, `clk` cycles waited after any `ctrl` change before a window starts.
- LOCK_N, 3, consecutive in-deadband windows required to assert `locked`.

Ports:
- clk  in  1  reference clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  loop enable (synchronous).
- win_len  in  WIN_W  window length in `clk` cycles; 0 treated as 1.
- target  in  CNT_W  expected rising-edge count per window.
- osc_in  in  1  divided oscillator phase, asynchronous to `clk`; high and low time each ≥ 2 `clk` periods.
- ctrl  out  2  oscillator control code.
- locked  out  1  frequency-lock indicator.
- meas_cnt  out  CNT_W  edge count of last completed window.
- meas_valid  out  1  one-cycle pulse when `meas_cnt` updates.

Behaviour:
- Reset values: ctrl=2'b01, locked=0, meas_cnt=0, meas_valid=0, FSM=IDLE, all counters 0, synchronizer flops 0.
- `osc_in` passes through a 2-flop synchronizer plus one edge-detect flop. A rising edge registers 3 cycles after the input transition.
- Edges are counted only in MEASURE. The edge counter saturates at all-ones.
- FSM states:
  - IDLE: en=1 → SETTLE, with settle counter cleared.
  - SETTLE: count SETTLE_CYC cycles → MEASURE, with window and edge counters cleared.
  - MEASURE: runs for max(win_len,1) cycles, then → UPDATE. `win_len` is sampled on entry to MEASURE.
  - UPDATE (1 cycle):
    - meas_cnt ← edge count; meas_valid=1.
    - diff = meas − target, computed signed at CNT_W+1 bits.
    - diff > DEADBAND (too fast): ctrl+1, saturating at 3.
    - diff < −DEADBAND (too slow): ctrl−1, saturating at 0.
    - Otherwise ctrl is held.
    - New ctrl is visible the cycle after UPDATE.
    - Next state: if ctrl changed → SETTLE, else → MEASURE (no settle).
- Lock counter:
  - Increments in UPDATE when |diff| ≤ DEADBAND, saturating at LOCK_N.
  - Clears when outside the deadband.
  - locked=1 while the counter equals LOCK_N; it rises the cycle after the qualifying UPDATE.
  - An outside-deadband result drops locked the cycle after UPDATE.
- If a step is saturated (code already 3 and too fast, or 0 and too slow): ctrl held, lock counter cleared, next state MEASURE.
- en deasserted in any state → IDLE next cycle:
  - counters and lock counter cleared; locked=0.
  - ctrl and meas_cnt hold their values.
  - A partial window is discarded; no meas_valid.
- `target` may change at any time and is sampled only in UPDATE.
- Asynchronous reset mid-operation returns everything to reset values immediately.

Optional Feature:
- Macro OSC_FLL_SAT_FLAG_EN.
- Defined:
  - Adds output `sat_err` (1 bit, reset 0).
  - sat_err is set in UPDATE when the required step is blocked by saturation.
  - sat_err clears in the next UPDATE that is not saturation-blocked, or when en=0.
- Undefined: port absent; saturation behaviour otherwise identical.

Test Plan:
- Reset, en=1, win_len=100, target=50, osc_in period 4 clk → after SETTLE (16) + 100 cycles: meas_valid pulse, meas_cnt=25. diff=−25 gives a too-slow step, so ctrl 1→0 and state re-enters SETTLE.
- osc_in period 2 clk (high 1 cycle) is an illegal input; use period 4 with target=10, win_len=100 → meas=25 >10. ctrl steps 1→2→3, then holds at 3; locked stays 0 (sat_err=1 if macro defined).
- target=25, win_len=100, osc_in period 4 → ctrl held at 1. locked rises one cycle after the 3rd UPDATE (3 windows of 100, one settle); meas_cnt=25 each window.
- After lock, change osc_in period to 5 (meas=20, diff=−5) → locked falls the cycle after the next UPDATE and ctrl 1→0.
- Drop en for 1 cycle mid-MEASURE → IDLE, no meas_valid, locked=0, ctrl unchanged. Re-raise en → SETTLE of 16 before the next window.
- Assert rst mid-MEASURE with ctrl=3, locked=1 → immediately ctrl=01, locked=0, meas_cnt=0. win_len=0 then gives 1-cycle windows with meas_cnt ≤ 1.
